// File: rtl/alu_pkg.sv
// Shared opcode encoding and command layout for the ALU command pipe.
// A command is packed as {op, a, b, tag}, with the tag in the least significant bits.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int OP_W      = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b0101;
    localparam logic [OP_W-1:0] OP_ROL  = 4'b0110;
    localparam logic [OP_W-1:0] OP_ROR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
    localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b1010;
    localparam logic [OP_W-1:0] OP_NAND = 4'b1011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1100;
    localparam logic [OP_W-1:0] OP_XNOR = 4'b1101;
    localparam logic [OP_W-1:0] OP_GT   = 4'b1110;
    localparam logic [OP_W-1:0] OP_EQ   = 4'b1111;

    // Default-width view of a command; parameterised instances use the same field order.
    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        logic [7:0]           tag;
    } alu_cmd_t;

    function automatic logic is_div_zero(input logic [OP_W-1:0] op, input logic b_zero);
        return (op == OP_DIV) && b_zero;
    endfunction

endpackage

// File: rtl/alu_cmd_pipe_if.sv
// Bundle of the command, ALU-facing and result channels of alu_cmd_pipe.
// Both handshakes transfer on a rising clk edge where valid && ready; a producer holds valid and its payload stable until that edge.
interface alu_cmd_pipe_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH,
    parameter int TAG_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_op;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;

    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [3:0]           alu_op;
    logic [WIDTH-1:0]     alu_result;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic                 out_err;
    logic [TAG_W-1:0]     out_tag;
    logic                 busy;

    modport slave (
        input  in_valid, in_op, in_a, in_b, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_err, out_tag, busy
    );

    modport master (
        output in_valid, in_op, in_a, in_b, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_err, out_tag, busy
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; the head is read from registered storage, so a push is
// only visible at dout after the edge that wrote it.
module alu_cmd_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/alu_cmd_pipe.sv
// Command FIFO -> registered issue stage (S1, drives the ALU) -> registered result stage (S2).
// Each accepted command carries a wrapping sequence tag; DIV by zero is flagged instead of trusted.
module alu_cmd_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic clk,
    input  logic rst,
    alu_cmd_pipe_if.slave bus
);
    localparam int CMD_W = OP_W + 2*WIDTH + TAG_W;
    localparam int AW    = $clog2(DEPTH);

    logic [CMD_W-1:0] fifo_din, fifo_dout;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;
    logic             push, pop, adv2, s2_load, div0;

    logic [TAG_W-1:0] tag_q, tag_d;
    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_err_q, s2_err_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    assign fifo_din = {bus.in_op, bus.in_a, bus.in_b, tag_q};
    assign push     = bus.in_valid && !fifo_full;
    assign adv2     = !s2_valid_q || bus.out_ready;
    assign pop      = !fifo_empty && (!s1_valid_q || adv2);
    assign s2_load  = s1_valid_q && adv2;
    assign div0     = is_div_zero(s1_op_q, s1_b_q == '0);

    alu_cmd_fifo #(.DW(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        tag_d       = push ? tag_q + TAG_W'(1) : tag_q;
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_err_d    = s2_err_q;
        s2_tag_d    = s2_tag_q;
        // S1 operand registers are left untouched when it empties so the ALU inputs hold.
        if (pop) begin
            s1_valid_d = 1'b1;
            s1_tag_d   = fifo_dout[TAG_W-1:0];
            s1_b_d     = fifo_dout[TAG_W +: WIDTH];
            s1_a_d     = fifo_dout[TAG_W+WIDTH +: WIDTH];
            s1_op_d    = fifo_dout[CMD_W-1 -: OP_W];
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s2_load) begin
            s2_valid_d  = 1'b1;
            s2_result_d = div0 ? '0 : bus.alu_result;
            s2_err_d    = div0;
            s2_tag_d    = s1_tag_q;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_err_q    <= 1'b0;
            s2_tag_q    <= '0;
        end else begin
            tag_q       <= tag_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_err_q    <= s2_err_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.alu_a      = s1_a_q;
    assign bus.alu_b      = s1_b_q;
    assign bus.alu_op     = s1_op_q;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_err    = s2_err_q;
    assign bus.out_tag    = s2_tag_q;
    assign bus.busy       = (fifo_count != '0) || s1_valid_q || s2_valid_q;
endmodule

// File: tb/tb_alu_cmd_pipe.sv
// Directed bench for alu_cmd_pipe with a small ALU model closing the loop
// and a scoreboard of expected {err, tag, result} in acceptance order.
module tb_alu_cmd_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 8;
    localparam int EXP_W = 1 + TAG_W + WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    alu_cmd_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb begin
        case (bus.alu_op)
            OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
            OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
            OP_DIV:  bus.alu_result = (bus.alu_b == '0) ? 32'hDEAD_BEEF : bus.alu_a / bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    int checks   = 0;
    int failures = 0;
    int n_seen   = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] exp_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] mk(input logic err, input int tag, input logic [WIDTH-1:0] res);
        return {err, TAG_W'(tag), res};
    endfunction

    // Scoreboard: a transfer completes at the next rising edge; inputs only change just after edges.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(bus.out_result), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_e = exp_q.pop_front();
                check("out_result", 64'(bus.out_result), 64'(exp_e[WIDTH-1:0]));
                check("out_tag", 64'(bus.out_tag), 64'(exp_e[WIDTH +: TAG_W]));
                check("out_err", 64'(bus.out_err), 64'(exp_e[EXP_W-1]));
            end
            n_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 100) begin
            tick();
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        check("drain_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int base;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_out_err", 64'(bus.out_err), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_alu_a", 64'(bus.alu_a), 64'd0);
        check("rst_alu_b", 64'(bus.alu_b), 64'd0);
        check("rst_alu_op", 64'(bus.alu_op), 64'd0);

        // Latency: accepted at edge k, issued at k+1, result valid after k+2.
        bus.out_ready = 1'b1;
        exp_q.push_back(mk(1'b0, 0, 32'd12));
        send(OP_ADD, 32'd5, 32'd7);
        check("lat_busy_k", 64'(bus.busy), 64'd1);
        check("lat_valid_k", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_alu_a", 64'(bus.alu_a), 64'd5);
        check("lat_alu_b", 64'(bus.alu_b), 64'd7);
        check("lat_alu_op", 64'(bus.alu_op), 64'(OP_ADD));
        check("lat_valid_k1", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_valid_k2", 64'(bus.out_valid), 64'd1);
        check("lat_result_k2", 64'(bus.out_result), 64'd12);
        drain();

        // Divide by zero, then a normal divide.
        do_reset();
        exp_q.push_back(mk(1'b1, 0, 32'd0));
        exp_q.push_back(mk(1'b0, 1, 32'd14));
        send(OP_DIV, 32'd100, 32'd0);
        send(OP_DIV, 32'd100, 32'd7);
        drain();

        // Burst against a stalled consumer: DEPTH+2 commands fit.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) exp_q.push_back(mk(1'b0, i, 32'(100 + i)));
        for (int i = 0; i < 6; i++) send(OP_ADD, 32'(i), 32'd100);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_ADD;
        bus.in_a     = 32'd6;
        bus.in_b     = 32'd100;
        repeat (3) tick();
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check("stall_out_tag", 64'(bus.out_tag), 64'd0);
        check("stall_out_result", 64'(bus.out_result), 64'd100);
        check("stall_alu_a", 64'(bus.alu_a), 64'd1);
        base = n_seen;
        bus.out_ready = 1'b1;
        send(OP_ADD, 32'd6, 32'd100);
        repeat (4) tick();
        check("burst_rate", 64'(n_seen - base), 64'd6);
        drain();

        // Tag wrap over 257 subtractions; a - b = -(i+1).
        do_reset();
        for (int i = 0; i < 257; i++) begin
            exp_q.push_back(mk(1'b0, i, 32'hFFFF_FFFF - 32'(i)));
            send(OP_SUB, 32'(i), 32'(2*i + 1));
        end
        drain();

        // Reset with commands in flight.
        do_reset();
        bus.out_ready = 1'b0;
        send(OP_ADD, 32'd1, 32'd1);
        send(OP_ADD, 32'd2, 32'd2);
        send(OP_ADD, 32'd3, 32'd3);
        do_reset();
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        exp_q.push_back(mk(1'b0, 0, 32'd3));
        send(OP_ADD, 32'd1, 32'd2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
